// File: rtl/acc_add.sv
// acc_add: pipelined accumulate/load/clear engine over a small register file.
//
// Each cycle one op is registered into stage S1 together with the forwarded
// current value of its target entry. The S2 commit logic is combinational
// from S1 and writes the array on the following edge, so an op is visible in
// the array two edges after it is presented. Entries are signed
// two's-complement; MAC saturates on overflow.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous, active-high reset
//   comp_en_add       op code: 00 IDLE, 01 MAC, 10 LOAD, 11 CLEAR
//   out_act_addr_add  target entry of the op
//   mult_result_add   signed operand (product from the multiply stage)
//   rd_en             readout request
//   rd_addr           entry to read out
//   rd_valid          rd_data holds a fresh readout this cycle
//   rd_data           readout value, held while rd_valid is low
//   busy              a non-IDLE op occupies S1 or S2 (registered)
module acc_add #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        comp_en_add,
    input  logic [ADDR_W-1:0] out_act_addr_add,
    input  logic [DATA_W-1:0] mult_result_add,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    localparam int unsigned N = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        OpIdle  = 2'b00,
        OpMac   = 2'b01,
        OpLoad  = 2'b10,
        OpClear = 2'b11
    } op_e;

    // Saturation bounds of the signed datapath.
    localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W - 1){1'b0}}};

    op_e in_op;
    assign in_op = op_e'(comp_en_add);

    // Stage S1 registers.
    op_e               s1_op_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [DATA_W-1:0] s1_operand_q;
    logic [DATA_W-1:0] s1_rdval_q;

    // Accumulator array, its next state and the output registers.
    logic [DATA_W-1:0] acc_q [N];
    logic [DATA_W-1:0] acc_d [N];
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic              busy_q;
    logic              busy_d;

    // S2 compute: one extra sign bit detects overflow of the MAC sum.
    logic [DATA_W:0]   mac_sum;
    logic [DATA_W-1:0] mac_sat;
    logic [DATA_W-1:0] result;
    logic              commit_we;
    logic              commit_clear;

    always_comb begin
        mac_sum = {s1_rdval_q[DATA_W-1], s1_rdval_q} +
                  {s1_operand_q[DATA_W-1], s1_operand_q};
        if (mac_sum[DATA_W] != mac_sum[DATA_W-1]) begin
            mac_sat = mac_sum[DATA_W] ? SatMin : SatMax;
        end else begin
            mac_sat = mac_sum[DATA_W-1:0];
        end
    end

    always_comb begin
        result       = '0;
        commit_we    = 1'b0;
        commit_clear = 1'b0;
        unique case (s1_op_q)
            OpMac: begin
                result    = mac_sat;
                commit_we = 1'b1;
            end
            OpLoad: begin
                result    = s1_operand_q;
                commit_we = 1'b1;
            end
            OpClear: commit_clear = 1'b1;
            OpIdle:  ;
            default: ;
        endcase
    end

    // Array contents after this edge's commit. Reading acc_d instead of acc_q
    // is what forwards the committing op into both S1 capture and readout.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            acc_d[i] = acc_q[i];
        end
        if (commit_clear) begin
            for (int i = 0; i < N; i++) begin
                acc_d[i] = '0;
            end
        end else if (commit_we) begin
            acc_d[s1_addr_q] = result;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = acc_d[rd_addr];
        end
    end

    // After the edge, S1 holds the incoming op and S2 holds the current S1 op.
    assign busy_d = (in_op != OpIdle) || (s1_op_q != OpIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_op_q      <= OpIdle;
            s1_addr_q    <= '0;
            s1_operand_q <= '0;
            s1_rdval_q   <= '0;
        end else begin
            s1_op_q      <= in_op;
            s1_addr_q    <= out_act_addr_add;
            s1_operand_q <= mult_result_add;
            s1_rdval_q   <= acc_d[out_act_addr_add];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_acc_add.sv
// Directed and randomized bench for acc_add. A sequential reference array
// applies each op at its commit edge; readouts and busy are compared every
// cycle, and directed sequences also check hand-computed values.
module tb_acc_add;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        comp_en_add;
    logic [ADDR_W-1:0] out_act_addr_add;
    logic [DATA_W-1:0] mult_result_add;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    acc_add #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .comp_en_add      (comp_en_add),
        .out_act_addr_add (out_act_addr_add),
        .mult_result_add  (mult_result_add),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] MAC   = 2'b01;
    localparam logic [1:0] LOAD  = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state.
    logic [DATA_W-1:0] mem [16];
    logic [1:0]        pend_op;
    logic [3:0]        pend_addr;
    logic [DATA_W-1:0] pend_opnd;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic              exp_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] sat(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) return 16'h7fff;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        pend_op   = IDLE;
        pend_addr = '0;
        pend_opnd = '0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_busy  = 1'b0;
    endtask

    // One clock: drive an op and an optional readout, advance the model, check.
    task automatic tick(input logic [1:0] op, input logic [3:0] addr,
                        input logic [DATA_W-1:0] opnd, input logic re, input logic [3:0] ra);
        comp_en_add      = op;
        out_act_addr_add = addr;
        mult_result_add  = opnd;
        rd_en            = re;
        rd_addr          = ra;
        @(posedge clk);
        case (pend_op)
            MAC:     mem[pend_addr] = sat(mem[pend_addr], pend_opnd);
            LOAD:    mem[pend_addr] = pend_opnd;
            CLEAR:   for (int i = 0; i < 16; i++) mem[i] = '0;
            default: ;
        endcase
        exp_valid = re;
        if (re) exp_data = mem[ra];
        exp_busy  = (op != IDLE) || (pend_op != IDLE);
        pend_op   = op;
        pend_addr = addr;
        pend_opnd = opnd;
        #1;
        check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_valid});
        check("rd_data", {16'b0, rd_data}, {16'b0, exp_data});
        check("busy", {31'b0, busy}, {31'b0, exp_busy});
    endtask

    task automatic idle();
        tick(IDLE, 4'd0, 16'd0, 1'b0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        tick(IDLE, 4'd0, 16'd0, 1'b1, a);
    endtask

    task automatic do_reset();
        comp_en_add = IDLE;
        rd_en       = 1'b0;
        rst         = 1'b1;
        model_reset();
        #2;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_rd_data", {16'b0, rd_data}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [1:0]        op;
        logic [3:0]        addr;
        logic [DATA_W-1:0] opnd;
        int                r;

        rst              = 1'b1;
        comp_en_add      = IDLE;
        out_act_addr_add = '0;
        mult_result_add  = '0;
        rd_en            = 1'b0;
        rd_addr          = '0;
        model_reset();
        do_reset();

        // LOAD 100 then MAC -30 back-to-back, read two cycles later.
        tick(LOAD, 4'd3, 16'd100, 1'b0, 4'd0);
        tick(MAC, 4'd3, -16'sd30, 1'b0, 4'd0);
        idle();
        rd(4'd3);
        check("load_mac_data", {16'b0, rd_data}, 32'd70);
        check("load_mac_valid", {31'b0, rd_valid}, 32'd1);
        idle();
        check("valid_one_cycle", {31'b0, rd_valid}, 32'd0);
        check("data_held", {16'b0, rd_data}, 32'd70);

        // CLEAR then four back-to-back MACs of 5.
        tick(CLEAR, 4'd9, 16'd0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) tick(MAC, 4'd0, 16'd5, 1'b0, 4'd0);
        idle();
        rd(4'd0);
        check("mac_chain", {16'b0, rd_data}, 32'd20);

        // Saturation at both ends.
        tick(LOAD, 4'd1, 16'h7fff, 1'b0, 4'd0);
        tick(MAC, 4'd1, 16'd10, 1'b0, 4'd0);
        tick(LOAD, 4'd2, 16'h8000, 1'b0, 4'd0);
        tick(MAC, 4'd2, 16'hffff, 1'b0, 4'd0);
        idle();
        rd(4'd1);
        check("sat_pos", {16'b0, rd_data}, 32'h7fff);
        rd(4'd2);
        check("sat_neg", {16'b0, rd_data}, 32'h8000);

        // CLEAR forwarding into an immediately following MAC.
        tick(LOAD, 4'd5, 16'd9, 1'b0, 4'd0);
        tick(CLEAR, 4'd0, 16'd0, 1'b0, 4'd0);
        tick(MAC, 4'd5, 16'd4, 1'b0, 4'd0);
        idle();
        rd(4'd5);
        check("clear_fwd", {16'b0, rd_data}, 32'd4);
        for (int i = 0; i < 16; i++) begin
            if (i != 5) begin
                rd(4'(i));
                check("clear_zero", {16'b0, rd_data}, 32'd0);
            end
        end

        // Readout alongside an op on the same entry returns the pre-op value.
        tick(LOAD, 4'd6, 16'd77, 1'b1, 4'd6);
        check("rd_pre_op", {16'b0, rd_data}, 32'd0);
        rd(4'd6);
        check("rd_fwd_commit", {16'b0, rd_data}, 32'd77);

        // Reset while a LOAD is in S1 discards it.
        tick(LOAD, 4'd7, 16'd55, 1'b0, 4'd0);
        do_reset();
        rd(4'd7);
        check("rst_discard", {16'b0, rd_data}, 32'd0);
        rd(4'd6);
        check("rst_cleared", {16'b0, rd_data}, 32'd0);

        // Randomized traffic against the reference.
        for (int c = 0; c < 10000; c++) begin
            r  = $urandom_range(0, 15);
            op = (r < 5) ? IDLE : (r < 10) ? MAC : (r < 15) ? LOAD : CLEAR;
            addr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3))
                                               : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) opnd = 16'($urandom);
            else opnd = 16'($urandom_range(0, 40) - 20);
            tick(op, addr, opnd, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_add.md
ACC_ADD -- requirements
Module: acc_add

Parameters
REQ-001 DATA_W, default 16, SHALL set the width of the signed two's-complement datapath and accumulator entries.
REQ-002 ADDR_W, default 4, SHALL set the accumulator address width; depth N = 2**ADDR_W.

Interface
REQ-003 clk  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 comp_en_add  input  2  SHALL carry the op code: 00 IDLE, 01 MAC, 10 LOAD, 11 CLEAR.
REQ-006 out_act_addr_add  input  ADDR_W  SHALL carry the target accumulator entry.
REQ-007 mult_result_add  input  DATA_W  SHALL carry the signed product from the multiply stage.
REQ-008 rd_en  input  1  SHALL request an accumulator readout.
REQ-009 rd_addr  input  ADDR_W  SHALL give the entry to read out.
REQ-010 rd_valid  output  1  SHALL mark rd_data valid.
REQ-011 rd_data  output  DATA_W  SHALL return the read-out entry value.
REQ-012 busy  output  1  SHALL be high while any non-IDLE op is in stage S1 or S2.

Function
REQ-013 Inputs SHALL be registered every cycle into stage S1 (op, addr, operand) with no stall and no back-pressure; one op per cycle.
REQ-014 In the same edge, S1 SHALL capture the operand-read value acc[addr], forwarded per REQ-019.
REQ-015 Stage S2 SHALL compute the result from the S1 registers and commit it to the array at the next edge; input-to-array latency is 2 cycles.
REQ-016 MAC: result = acc + operand, saturated to [-2**(DATA_W-1), 2**(DATA_W-1)-1] on signed overflow.
REQ-017 LOAD: result = operand; the old value is ignored.
REQ-018 CLEAR: on commit, all N entries SHALL become 0; addr is ignored.
REQ-019 Forwarding: if the op in S1 commits in the same edge that a new op is captured into S1, the captured read value SHALL be the committed result (same address) or 0 (committing op is CLEAR); otherwise it is the array contents.
REQ-020 IDLE SHALL leave the array untouched; its captured read value is don't-care.
REQ-021 Readout: rd_en at edge t SHALL give rd_valid=1 and rd_data = acc[rd_addr] in the following cycle, including any commit at edge t (forwarded); otherwise rd_valid=0 and rd_data holds its last value.
REQ-022 Simultaneous readout and op on the same address SHALL NOT stall either; the readout returns the pre-op value per REQ-021.
REQ-023 busy SHALL equal (S1 op != IDLE) OR (S2 op != IDLE), as a registered value.

Reset
REQ-024 On rst high, all S1/S2 registers SHALL be cleared with op = IDLE.
REQ-025 On rst high, all N accumulator entries, rd_valid, rd_data and busy SHALL be 0.
REQ-026 An op in flight at reset assertion SHALL be discarded and not committed.
REQ-027 The first op is accepted at the first rising edge after rst deasserts.

Verification
REQ-028 Reset, then LOAD addr3=100, then MAC addr3=-30 back-to-back, then rd_en addr3 two cycles later -> rd_data=70, rd_valid=1 for one cycle.
REQ-029 Four consecutive MACs of 5 to addr0 after CLEAR -> acc[0]=20; this exercises forwarding every cycle.
REQ-030 LOAD addr1=32767, then MAC addr1=10 -> acc[1]=32767; LOAD addr2=-32768, then MAC addr2=-1 -> acc[2]=-32768.
REQ-031 LOAD addr5=9, CLEAR, then MAC addr5=4 immediately -> acc[5]=4 (forwarded 0), and all other entries read 0.
REQ-032 Assert rst while a LOAD addr7=55 is in S1 -> acc[7] reads 0 after reset, and busy=0.
REQ-033 Interleave IDLE cycles and random ops against a reference model for 10k cycles -> readouts match, and busy matches the REQ-023 definition.
